// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Memory read port, redirect request and decode handshake of the fetch stage.
interface fetch_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_fault;

  modport master (
    output imem_addr,
    input  imem_rd,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc,
    output id_pc4,
    output id_fault
  );

  modport slave (
    input  imem_addr,
    output imem_rd,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc,
    input  id_pc4,
    input  id_fault
  );

endinterface

// File: rtl/fetch_queue.sv
// Small power-of-two FIFO of fetch entries; push and pop may coincide even when full.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  fetch_entry_t              push_entry,
  output fetch_entry_t              head,
  output logic [$clog2(QDEPTH):0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] QD_C = CW'(QDEPTH);
  localparam fetch_entry_t  RST_ENTRY = '{pc: 32'h0, instr: NOP_INSTR, fault: 1'b0};

  fetch_entry_t  mem_q [QDEPTH];
  fetch_entry_t  mem_d [QDEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage resets too so the head presents a NOP at PC 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= RST_ENTRY;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == QD_C);
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, run/halt FSM, fault detection and queue control.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 2048,
  parameter int          QDEPTH     = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  localparam int            CW         = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QD_C       = CW'(QDEPTH);
  localparam logic [31:0]   IMEM_LIMIT = 32'(IMEM_WORDS);
  localparam logic [0:0]    ST_RUN     = S_RUN;
  localparam logic [0:0]    ST_HALT    = S_HALT;

  logic [31:0]   pc_q, pc_d;
  logic [0:0]    state_q, state_d;

  logic          q_push, q_pop, q_flush;
  fetch_entry_t  q_entry, q_head;
  logic [CW-1:0] q_count;
  logic          q_full, q_empty;

  logic          fault_now;
  logic          pop_req;
  logic          push_req;

  assign fault_now = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= IMEM_LIMIT);
  assign pop_req   = !q_empty && bus.id_ready;
  assign push_req  = (state_q == ST_RUN) && ((q_count < QD_C) || (q_full && pop_req));

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    q_push  = 1'b0;
    q_pop   = 1'b0;
    q_flush = 1'b0;
    q_entry = '{pc: pc_q, instr: bus.imem_rd, fault: 1'b0};
    if (bus.redirect_valid) begin
      // Redirect wins: whatever would have been pushed or popped this cycle is dropped.
      q_flush = 1'b1;
      pc_d    = bus.redirect_pc;
      state_d = ST_RUN;
    end else begin
      q_pop = pop_req;
      if (push_req) begin
        q_push = 1'b1;
        if (fault_now) begin
          q_entry = '{pc: pc_q, instr: NOP_INSTR, fault: 1'b1};
          state_d = ST_HALT;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (q_push),
    .pop        (q_pop),
    .flush      (q_flush),
    .push_entry (q_entry),
    .head       (q_head),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign bus.imem_addr = pc_q;
  assign bus.id_valid  = !q_empty;
  assign bus.id_instr  = q_head.instr;
  assign bus.id_pc     = q_head.pc;
  assign bus.id_pc4    = q_head.pc + 32'd4;
  assign bus.id_fault  = q_head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, backpressure, redirects, faults, reset.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  fetch_if bus ();

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (2048),
    .QDEPTH     (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0050_0113;
      32'h8:   return 32'h3e20_8363;
      32'hC:   return 32'h0000_0013;
      default: return 32'hC000_0000 ^ a;
    endcase
  endfunction

  assign bus.imem_rd = mem_word(bus.imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr, input logic fault);
    check({tag, ".valid"}, 32'(bus.id_valid), 32'd1);
    check({tag, ".pc"},    bus.id_pc,          pc);
    check({tag, ".instr"}, bus.id_instr,       instr);
    check({tag, ".fault"}, 32'(bus.id_fault),  32'(fault));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".valid"}, 32'(bus.id_valid), 32'd0);
    check({tag, ".instr"}, bus.id_instr,       32'h0000_0013);
    check({tag, ".pc"},    bus.id_pc,          32'h0);
    check({tag, ".pc4"},   bus.id_pc4,         32'h4);
    check({tag, ".fault"}, 32'(bus.id_fault),  32'd0);
    check({tag, ".addr"},  bus.imem_addr,      32'h0);
  endtask

  // Called at posedge+1: reset across one edge, released between edges.
  task automatic do_reset(input logic ready);
    rst_n = 1'b0;
    bus.id_ready = ready;
    bus.redirect_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst");
    tick();
    tick();
    rst_n = 1'b1;

    // Stream with id_ready=1
    tick(); check_head("s0", 32'h0, 32'h0050_0093, 1'b0);
    check("s0.pc4", bus.id_pc4, 32'h4);
    tick(); check_head("s1", 32'h4, 32'h0050_0113, 1'b0);
    tick(); check_head("s2", 32'h8, 32'h3e20_8363, 1'b0);
    tick(); check_head("s3", 32'hC, 32'h0000_0013, 1'b0);
    check("s3.pc4", bus.id_pc4, 32'h10);

    // Backpressure
    do_reset(1'b0);
    tick(); check_head("bp0", 32'h0, 32'h0050_0093, 1'b0);
    for (int i = 1; i < 5; i++) begin
      tick();
      check_head("bp_hold", 32'h0, 32'h0050_0093, 1'b0);
      check("bp_addr", bus.imem_addr, 32'h8);
    end
    bus.id_ready = 1'b1;
    tick(); check_head("bp_r1", 32'h4, 32'h0050_0113, 1'b0);
    check("bp_r1.addr", bus.imem_addr, 32'hC);
    tick(); check_head("bp_r2", 32'h8, 32'h3e20_8363, 1'b0);

    // Redirect while full and id_ready=1
    do_reset(1'b0);
    tick();
    tick();
    check("rf_full.addr", bus.imem_addr, 32'h8);
    bus.id_ready = 1'b1;
    redirect(32'h100);
    check("rf_bubble.valid", 32'(bus.id_valid), 32'd0);
    check("rf_bubble.addr", bus.imem_addr, 32'h100);
    tick(); check_head("rf_t0", 32'h100, 32'hC000_0100, 1'b0);
    tick(); check_head("rf_t1", 32'h104, 32'hC000_0104, 1'b0);

    // Misaligned redirect
    redirect(32'h102);
    check("mis_bubble.valid", 32'(bus.id_valid), 32'd0);
    tick(); check_head("mis_f", 32'h102, 32'h0000_0013, 1'b1);
    check("mis_f.pc4", bus.id_pc4, 32'h106);
    tick();
    check("mis_h0.valid", 32'(bus.id_valid), 32'd0);
    check("mis_h0.addr", bus.imem_addr, 32'h102);
    tick();
    check("mis_h1.valid", 32'(bus.id_valid), 32'd0);
    check("mis_h1.addr", bus.imem_addr, 32'h102);
    redirect(32'h0);
    check("mis_res_bubble.valid", 32'(bus.id_valid), 32'd0);
    tick(); check_head("mis_res", 32'h0, 32'h0050_0093, 1'b0);

    // Upper bound of instruction memory
    redirect(32'h1FFC);
    check("bnd_bubble.valid", 32'(bus.id_valid), 32'd0);
    tick(); check_head("bnd_last", 32'h1FFC, 32'hC000_1FFC, 1'b0);
    tick(); check_head("bnd_fault", 32'h2000, 32'h0000_0013, 1'b1);
    tick();
    check("bnd_halt.valid", 32'(bus.id_valid), 32'd0);
    check("bnd_halt.addr", bus.imem_addr, 32'h2000);
    tick();
    check("bnd_halt2.valid", 32'(bus.id_valid), 32'd0);

    // Reset mid-stream, asserted between edges
    redirect(32'h0);
    tick();
    tick(); check_head("mr_pre", 32'h4, 32'h0050_0113, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mr_rst");
    tick();
    rst_n = 1'b1;
    tick(); check_head("mr_post", 32'h0, 32'h0050_0093, 1'b0);
    check("mr_post.addr", bus.imem_addr, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
